// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch bus: memory read port plus dispatcher valid/ready handshake.
//  master (fetch unit): drives address, nRead, instr_valid, opcode/dest/src1/src2, pc
//                       samples DataIn, instr_ready
//  slave  (memory + dispatcher): the mirror image
interface instruction_fetch_unit_if;
    logic [15:0]  address;
    logic         nRead;
    logic [255:0] DataIn;
    logic         instr_valid;
    logic         instr_ready;
    logic [7:0]   opcode;
    logic [7:0]   dest;
    logic [7:0]   src1;
    logic [7:0]   src2;
    logic [11:0]  pc;

    modport master (
        output address, nRead, instr_valid, opcode, dest, src1, src2, pc,
        input  DataIn, instr_ready
    );

    modport slave (
        input  address, nRead, instr_valid, opcode, dest, src1, src2, pc,
        output DataIn, instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches 32-bit instruction words from the instruction memory one at a time,
// splits them into opcode/dest/src1/src2 and presents them to the dispatcher.
// Stops on opcode FFh (stop word, never presented) or when pc reaches DEPTH.
//  Clk, nReset : clock, asynchronous active-low reset
//  start       : 1-cycle pulse, honoured in IDLE/HALT only
//  bus         : memory read port and dispatcher handshake (master side)
//  busy        : high in REQ, CAPT, VALID
//  halted      : high in HALT
//  overrun     : sticky, halt was caused by pc reaching DEPTH
module instruction_fetch_unit #(
    parameter logic [3:0]  INSTR_SEL = 4'b1000,
    parameter int unsigned DEPTH     = 10,
    parameter logic [11:0] START_PC  = 12'h000
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic                     start,
    instruction_fetch_unit_if.master bus,
    output logic                     busy,
    output logic                     halted,
    output logic                     overrun
);
    localparam int unsigned PC_W   = 12;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_VALID = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // One extra bit so DEPTH == 4096 compares correctly against pc+1.
    localparam logic [PC_W:0] DEPTH_END = (PC_W+1)'(DEPTH);
    localparam logic [7:0]    STOP_OP   = 8'hFF;

    logic [2:0]        state_q,   state_n;
    logic [PC_W-1:0]   pc_q,      pc_n;
    logic [ADDR_W-1:0] addr_q,    addr_n;
    logic              nread_q,   nread_n;
    logic              valid_q,   valid_n;
    logic [WORD_W-1:0] word_q,    word_n;
    logic              busy_q,    busy_n;
    logic              halted_q,  halted_n;
    logic              overrun_q, overrun_n;
    logic [PC_W:0]     pc_inc;

    // Only the low word of the memory bus carries the instruction.
    logic unused_data_hi;
    assign unused_data_hi = ^bus.DataIn[255:WORD_W];

    assign pc_inc = {1'b0, pc_q} + (PC_W+1)'(1);

    // State and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            pc_q      <= START_PC;
            addr_q    <= '0;
            nread_q   <= 1'b1;
            valid_q   <= 1'b0;
            word_q    <= '0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            addr_q    <= addr_n;
            nread_q   <= nread_n;
            valid_q   <= valid_n;
            word_q    <= word_n;
            busy_q    <= busy_n;
            halted_q  <= halted_n;
            overrun_q <= overrun_n;
        end
    end

    // Next state and next register values; the strobe is computed one cycle
    // ahead so nRead/address are low/valid exactly while in REQ.
    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        addr_n    = '0;
        nread_n   = 1'b1;
        valid_n   = valid_q;
        word_n    = word_q;
        overrun_n = overrun_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n   = S_REQ;
                    pc_n      = START_PC;
                    overrun_n = 1'b0;
                    addr_n    = {INSTR_SEL, START_PC};
                    nread_n   = 1'b0;
                end
            end
            S_REQ: begin
                state_n = S_CAPT;
            end
            S_CAPT: begin
                // DataIn is only looked at here, so X elsewhere cannot leak.
                word_n = bus.DataIn[WORD_W-1:0];
                if (bus.DataIn[31:24] == STOP_OP) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_VALID;
                    valid_n = 1'b1;
                end
            end
            S_VALID: begin
                if (valid_q && bus.instr_ready) begin
                    valid_n = 1'b0;
                    pc_n    = pc_inc[PC_W-1:0];
                    if (pc_inc == DEPTH_END) begin
                        state_n   = S_HALT;
                        overrun_n = 1'b1;
                    end else begin
                        state_n = S_REQ;
                        addr_n  = {INSTR_SEL, pc_inc[PC_W-1:0]};
                        nread_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase

        busy_n   = (state_n == S_REQ) || (state_n == S_CAPT) || (state_n == S_VALID);
        halted_n = (state_n == S_HALT);
    end

    assign bus.address     = addr_q;
    assign bus.nRead       = nread_q;
    assign bus.instr_valid = valid_q;
    assign bus.opcode      = word_q[31:24];
    assign bus.dest        = word_q[23:16];
    assign bus.src1        = word_q[15:8];
    assign bus.src2        = word_q[7:0];
    assign bus.pc          = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
    assign overrun         = overrun_q;
endmodule
